// File: rtl/car_park_pkg.sv
// car_park_pkg: shared FSM state type and width helpers for the car-park entry controller.
package car_park_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_PW, OPEN, LOCKED} state_t;

    function automatic int width_for(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int timer_w(input int gate_cycles, input int lock_cycles);
        return width_for(gate_cycles > lock_cycles ? gate_cycles : lock_cycles);
    endfunction

endpackage

// File: rtl/car_park_timer.sv
// car_park_timer: loadable down-counter; done marks the last cycle of the loaded interval.
module car_park_timer #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] value;

    always_ff @(posedge clock) begin
        if (reset)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (value != '0)
            value <= value - 1'b1;
    end

    assign done = value == W'(1);

endmodule

// File: rtl/car_park_controller.sv
// car_park_controller: password-checked entry gate with keypad lockout and occupancy tracking.
module car_park_controller
    import car_park_pkg::*;
#(
    parameter int                  PW_WIDTH    = 4,
    parameter logic [PW_WIDTH-1:0] PASSWORD    = 4'b1010,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  LOCK_CYCLES = 16,
    parameter int                  GATE_CYCLES = 4,
    parameter int                  CAPACITY    = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            entry_sensor,
    input  logic                            exit_sensor,
    input  logic                            pw_valid,
    input  logic [PW_WIDTH-1:0]             password,
    output logic                            gate_open,
    output logic                            green,
    output logic                            red,
    output logic                            lockout,
    output logic                            full,
    output logic [$clog2(CAPACITY+1)-1:0]   count
);

    localparam int TRW = width_for(MAX_TRIES);
    localparam int TW  = timer_w(GATE_CYCLES, LOCK_CYCLES);

    state_t          state, state_nx;
    logic [TRW-1:0]  tries, tries_nx, tries_inc;
    logic            inc, dec, load, done;
    logic [TW-1:0]   load_val;

    car_park_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    assign tries_inc = tries + 1'b1;

    always_comb begin
        state_nx = state;
        tries_nx = tries;
        inc      = 1'b0;
        load     = 1'b0;
        load_val = TW'(GATE_CYCLES);
        unique case (state)
            IDLE:    if (entry_sensor && !full) state_nx = WAIT_PW;
            WAIT_PW: begin
                if (pw_valid && password == PASSWORD) begin
                    state_nx = OPEN;
                    tries_nx = '0;
                    inc      = 1'b1;
                    load     = 1'b1;
                end else if (pw_valid) begin
                    tries_nx = tries_inc;
                    if (tries_inc == TRW'(MAX_TRIES)) begin
                        state_nx = LOCKED;
                        load     = 1'b1;
                        load_val = TW'(LOCK_CYCLES);
                    end
                end else if (!entry_sensor) begin
                    state_nx = IDLE;
                    tries_nx = '0;
                end
            end
            OPEN:    if (done) state_nx = IDLE;
            LOCKED:  if (done) begin
                state_nx = IDLE;
                tries_nx = '0;
            end
        endcase
    end

    // Exit at zero occupancy is ignored; simultaneous entry and exit cancel.
    assign dec = exit_sensor && count != '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            tries <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            tries <= tries_nx;
            if (inc && !dec)
                count <= count + 1'b1;
            else if (dec && !inc)
                count <= count - 1'b1;
        end
    end

    assign full      = count == ($clog2(CAPACITY+1))'(CAPACITY);
    assign gate_open = state == OPEN;
    assign green     = state == OPEN;
    assign lockout   = state == LOCKED;
    assign red       = state == WAIT_PW || state == LOCKED || (state == IDLE && full);

endmodule
